// File: rtl/aq_vdsp_64_bit_norm.sv
// rtl/aq_vdsp_64_bit_norm.sv - SIMD normalize shifter, two-stage valid/ready pipeline
// Shifts each packed element left by its clamped leading-bit count; reports lane shamts and zero flags.
module aq_vdsp_64_bit_norm (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        ex1_vld,
  output logic        ex1_rdy,
  input  logic        ex1_flush,
  input  logic [3:0]  ex1_size,
  input  logic        ex1_sign,
  input  logic [63:0] ex1_src,
  input  logic [39:0] ff1_8_bit,
  input  logic [23:0] ff1_16_bit,
  input  logic [13:0] ff1_32_bit,
  input  logic [7:0]  ff1_64_bit,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [63:0] out_data,
  output logic [55:0] out_shamt,
  output logic [7:0]  out_zero
);

  localparam int SILEN = 64;
  localparam int BYTE  = 8;

  logic             s1_vld_q;
  logic [SILEN-1:0] s1_src_q;
  logic [3:0]       s1_size_q;
  logic [55:0]      s1_shamt_q;
  logic [7:0]       s1_zero_q;

  logic             s2_vld_q;
  logic [SILEN-1:0] s2_data_q;
  logic [55:0]      s2_shamt_q;
  logic [7:0]       s2_zero_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             accept;

  logic [3:0]       size_d;
  logic [55:0]      shamt_d;
  logic [7:0]       zero_d;
  logic [SILEN-1:0] data_d;

  // Counts exclude the sign bit, so signed mode shifts exactly like unsigned.
  logic             sign_unused;
  assign sign_unused = ex1_sign;

  assign s2_adv  = ~s2_vld_q | out_rdy;
  assign s1_adv  = ~s1_vld_q | s2_adv;
  assign ex1_rdy = s1_adv;
  assign accept  = ex1_vld & s1_adv & ~ex1_flush;

  always_comb begin
    size_d = 4'b0000;
    if (ex1_size[3])      size_d = 4'b1000;
    else if (ex1_size[2]) size_d = 4'b0100;
    else if (ex1_size[1]) size_d = 4'b0010;
    else if (ex1_size[0]) size_d = 4'b0001;
  end

  // Each element reports its clamped count in its lowest byte lane only.
  always_comb begin
    shamt_d = '0;
    zero_d  = '0;
    if (size_d[3]) begin
      shamt_d[6:0] = (ff1_64_bit > 8'd64) ? 7'd64 : ff1_64_bit[6:0];
      zero_d       = {8{ex1_src == 64'd0}};
    end else if (size_d[2]) begin
      for (int j = 0; j < 2; j++) begin
        shamt_d[28*j +: 7] = (ff1_32_bit[7*j +: 7] > 7'd32) ? 7'd32 : ff1_32_bit[7*j +: 7];
        zero_d[4*j +: 4]   = {4{ex1_src[32*j +: 32] == 32'd0}};
      end
    end else if (size_d[1]) begin
      for (int j = 0; j < 4; j++) begin
        shamt_d[14*j +: 7] = (ff1_16_bit[6*j +: 6] > 6'd16) ? 7'd16 : {1'b0, ff1_16_bit[6*j +: 6]};
        zero_d[2*j +: 2]   = {2{ex1_src[16*j +: 16] == 16'd0}};
      end
    end else if (size_d[0]) begin
      for (int j = 0; j < 8; j++) begin
        shamt_d[7*j +: 7] = (ff1_8_bit[5*j +: 5] > 5'd8) ? 7'd8 : {2'b00, ff1_8_bit[5*j +: 5]};
        zero_d[j]         = (ex1_src[BYTE*j +: BYTE] == 8'd0);
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        zero_d[j] = (ex1_src[BYTE*j +: BYTE] == 8'd0);
      end
    end
  end

  // Shifts happen at element width, so a count equal to W flushes the element to zero.
  always_comb begin
    data_d = s1_src_q;
    if (s1_size_q[3]) begin
      data_d = s1_src_q << s1_shamt_q[6:0];
    end else if (s1_size_q[2]) begin
      for (int j = 0; j < 2; j++) begin
        data_d[32*j +: 32] = s1_src_q[32*j +: 32] << s1_shamt_q[28*j +: 7];
      end
    end else if (s1_size_q[1]) begin
      for (int j = 0; j < 4; j++) begin
        data_d[16*j +: 16] = s1_src_q[16*j +: 16] << s1_shamt_q[14*j +: 7];
      end
    end else if (s1_size_q[0]) begin
      for (int j = 0; j < 8; j++) begin
        data_d[BYTE*j +: BYTE] = s1_src_q[BYTE*j +: BYTE] << s1_shamt_q[7*j +: 7];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_vld_q   <= 1'b0;
      s1_src_q   <= '0;
      s1_size_q  <= '0;
      s1_shamt_q <= '0;
      s1_zero_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_shamt_q <= '0;
      s2_zero_q  <= '0;
    end else begin
      if (ex1_flush) begin
        s1_vld_q <= 1'b0;
        s2_vld_q <= 1'b0;
      end else begin
        if (s1_adv) s1_vld_q <= ex1_vld;
        if (s2_adv) s2_vld_q <= s1_vld_q;
        if (accept) begin
          s1_src_q   <= ex1_src;
          s1_size_q  <= size_d;
          s1_shamt_q <= shamt_d;
          s1_zero_q  <= zero_d;
        end
        if (s2_adv && s1_vld_q) begin
          s2_data_q  <= data_d;
          s2_shamt_q <= s1_shamt_q;
          s2_zero_q  <= s1_zero_q;
        end
      end
    end
  end

  assign out_vld   = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_shamt = s2_shamt_q;
  assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_aq_vdsp_64_bit_norm.sv
// tb/tb_aq_vdsp_64_bit_norm.sv - self-checking bench for the SIMD normalize shifter
// Directed scenarios plus a random stream scored against an arithmetic per-element model.
module tb_aq_vdsp_64_bit_norm;

  logic        clk;
  logic        rst;
  logic        ex1_vld;
  logic        ex1_rdy;
  logic        ex1_flush;
  logic [3:0]  ex1_size;
  logic        ex1_sign;
  logic [63:0] ex1_src;
  logic [39:0] ff1_8_bit;
  logic [23:0] ff1_16_bit;
  logic [13:0] ff1_32_bit;
  logic [7:0]  ff1_64_bit;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_data;
  logic [55:0] out_shamt;
  logic [7:0]  out_zero;

  int errors = 0;
  int checks = 0;

  aq_vdsp_64_bit_norm dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .ex1_vld(ex1_vld),
    .ex1_rdy(ex1_rdy),
    .ex1_flush(ex1_flush),
    .ex1_size(ex1_size),
    .ex1_sign(ex1_sign),
    .ex1_src(ex1_src),
    .ff1_8_bit(ff1_8_bit),
    .ff1_16_bit(ff1_16_bit),
    .ff1_32_bit(ff1_32_bit),
    .ff1_64_bit(ff1_64_bit),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_data(out_data),
    .out_shamt(out_shamt),
    .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element-wise reference: pick width, clamp count, shift within a masked element.
  function automatic void ref_model(input logic [3:0] sz, input logic [63:0] src,
                                    input logic [39:0] c8, input logic [23:0] c16,
                                    input logic [13:0] c32, input logic [7:0] c64,
                                    output logic [63:0] d, output logic [55:0] sh,
                                    output logic [7:0] z);
    int w, n, lanes, cnt;
    logic [127:0] t;
    logic [63:0] mask, elem;
    d = '0; sh = '0; z = '0;
    if (sz[3]) w = 64; else if (sz[2]) w = 32; else if (sz[1]) w = 16; else if (sz[0]) w = 8; else w = 0;
    if (w == 0) begin
      d = src;
      for (int i = 0; i < 8; i++) z[i] = (((src >> (8*i)) & 64'hff) == 64'd0);
    end else begin
      mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      n     = 64 / w;
      lanes = w / 8;
      for (int e = 0; e < n; e++) begin
        elem = (src >> (e*w)) & mask;
        case (w)
          8:       cnt = int'((c8  >> (5*e)) & 40'h1f);
          16:      cnt = int'((c16 >> (6*e)) & 24'h3f);
          32:      cnt = int'((c32 >> (7*e)) & 14'h7f);
          default: cnt = int'(c64);
        endcase
        if (cnt > w) cnt = w;
        t  = {64'd0, elem} << cnt;
        d  = d | ((t[63:0] & mask) << (e*w));
        sh = sh | (56'(cnt) << (7*e*lanes));
        if (elem == 64'd0)
          for (int k = 0; k < lanes; k++) z[e*lanes + k] = 1'b1;
      end
    end
  endfunction

  task automatic set_in(input logic [3:0] sz, input logic sg, input logic [63:0] src,
                        input logic [39:0] c8, input logic [23:0] c16,
                        input logic [13:0] c32, input logic [7:0] c64);
    ex1_size = sz; ex1_sign = sg; ex1_src = src;
    ff1_8_bit = c8; ff1_16_bit = c16; ff1_32_bit = c32; ff1_64_bit = c64;
  endtask

  // Presents one item on an idle pipe and captures its result; lat=0 means no result.
  task automatic run_one(output logic [63:0] d, output logic [55:0] s,
                         output logic [7:0] z, output int lat);
    lat = 0; d = '0; s = '0; z = '0;
    ex1_vld = 1'b1; out_rdy = 1'b1; ex1_flush = 1'b0;
    @(posedge clk); #1;
    ex1_vld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_vld) begin
        lat = i; d = out_data; s = out_shamt; z = out_zero;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex1_vld = 1'b0; ex1_flush = 1'b0; out_rdy = 1'b0;
    set_in(4'd0, 1'b0, 64'd0, 40'd0, 24'd0, 14'd0, 8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_vld !== 1'b0 || out_data !== 64'd0 || out_shamt !== 56'd0 || out_zero !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b data=%h shamt=%h zero=%h required all 0", out_vld, out_data, out_shamt, out_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ex1_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", ex1_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte();
    logic [63:0] d, ed; logic [55:0] s, es; logic [7:0] z, ez; int lat;
    set_in(4'b0001, 1'b0, 64'h8040_2010_0804_0001, {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd7},
           24'd0, 14'd0, 8'd0);
    ex1_src[15:8] = 8'h00;
    ref_model(ex1_size, ex1_src, ff1_8_bit, ff1_16_bit, ff1_32_bit, ff1_64_bit, ed, es, ez);
    run_one(d, s, z, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL byte_latency: got %0d required 2", lat); end
    checks++;
    if (d[15:0] !== 16'h0080 || s[13:0] !== {7'd8, 7'd7} || z[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL byte_plan: data=%h shamt=%h zero=%b required 0080/%h/10", d[15:0], s[13:0], z[1:0], {7'd8, 7'd7});
    end
    checks++;
    if (d !== ed || s !== es || z !== ez) begin
      errors++; $display("FAIL byte_model: got %h/%h/%h required %h/%h/%h", d, s, z, ed, es, ez);
    end
  endtask

  task automatic test_half_signed();
    logic [63:0] d; logic [55:0] s; logic [7:0] z; int lat;
    set_in(4'b0010, 1'b1, 64'h0000_0000_0003_FFF0, 40'd0, {6'd0, 6'd0, 6'd13, 6'd11}, 14'd0, 8'd0);
    run_one(d, s, z, lat);
    checks++;
    if (lat !== 2 || d[31:0] !== 32'h6000_8000) begin
      errors++; $display("FAIL half_signed_data: lat=%0d data=%h required 2/60008000", lat, d[31:0]);
    end
    checks++;
    if (s !== {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd13, 7'd0, 7'd11} || z !== 8'b1111_0000) begin
      errors++; $display("FAIL half_signed_shamt: shamt=%h zero=%b", s, z);
    end
  endtask

  task automatic test_dword();
    logic [63:0] d; logic [55:0] s; logic [7:0] z; int lat;
    set_in(4'b1000, 1'b0, 64'd1, 40'd0, 24'd0, 14'd0, 8'd63);
    run_one(d, s, z, lat);
    checks++;
    if (d !== 64'h8000_0000_0000_0000 || s !== 56'd63 || z !== 8'd0) begin
      errors++; $display("FAIL dword: data=%h shamt=%h zero=%h required 8000000000000000/3f/00", d, s, z);
    end
  endtask

  task automatic test_word_clamp();
    logic [63:0] d; logic [55:0] s; logic [7:0] z; int lat;
    set_in(4'b0100, 1'b0, 64'h4000_0000_0000_FFFF, 40'd0, 24'd0, {7'd1, 7'd40}, 8'd0);
    run_one(d, s, z, lat);
    checks++;
    if (d !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL word_clamp_data: got %h required 8000000000000000", d);
    end
    checks++;
    if (s[6:0] !== 7'd32 || s[34:28] !== 7'd1 || z !== 8'd0) begin
      errors++; $display("FAIL word_clamp_shamt: lane0=%0d lane4=%0d zero=%h required 32/1/00", s[6:0], s[34:28], z);
    end
  endtask

  task automatic test_size_decode();
    logic [63:0] d, ed; logic [55:0] s, es; logic [7:0] z, ez; int lat;
    set_in(4'b0000, 1'b0, 64'h0012_0000_0001_00FF, 40'hFF_FFFF_FFFF, 24'hFF_FFFF, 14'h3FFF, 8'hFF);
    run_one(d, s, z, lat);
    checks++;
    if (d !== 64'h0012_0000_0001_00FF || s !== 56'd0 || z !== 8'b1011_1010) begin
      errors++; $display("FAIL size_none: data=%h shamt=%h zero=%b", d, s, z);
    end
    set_in(4'b0111, 1'b0, 64'h0001_0002_0003_0004, 40'd0, 24'd0, {7'd2, 7'd3}, 8'd5);
    ref_model(ex1_size, ex1_src, ff1_8_bit, ff1_16_bit, ff1_32_bit, ff1_64_bit, ed, es, ez);
    run_one(d, s, z, lat);
    checks++;
    if (d !== ed || s !== es || z !== ez || d !== 64'h0004_0008_0018_0020) begin
      errors++; $display("FAIL size_priority: got %h/%h/%h required %h/%h/%h", d, s, z, ed, es, ez);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ed[3]; logic [55:0] es[3]; logic [7:0] ez[3];
    logic [63:0] srcs[3];
    srcs[0] = 64'h0000_0001_0000_0010; srcs[1] = 64'h0000_0100_0000_0002; srcs[2] = 64'h00F0_0000_1234_0000;
    for (int i = 0; i < 3; i++)
      ref_model(4'b0100, srcs[i], 40'd0, 24'd0, {7'(i+4), 7'(i+1)}, 8'd0, ed[i], es[i], ez[i]);
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0100, 1'b0, srcs[i], 40'd0, 24'd0, {7'(i+4), 7'(i+1)}, 8'd0);
      ex1_vld = 1'b1;
      if (i < 2) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ex1_rdy !== 1'b0 || out_vld !== 1'b1 || out_data !== ed[0]) begin
        errors++; $display("FAIL bp_full: rdy=%b vld=%b data=%h required 0/1/%h", ex1_rdy, out_vld, out_data, ed[0]);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b1 || out_data !== ed[i] || out_shamt !== es[i] || out_zero !== ez[i]) begin
        errors++;
        $display("FAIL bp_order_%0d: vld=%b got %h/%h/%h required %h/%h/%h", i, out_vld, out_data, out_shamt, out_zero, ed[i], es[i], ez[i]);
      end
      @(posedge clk); #1;
      ex1_vld = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_drain: out_vld=%b required 0", out_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_rdy = 1'b1;
    set_in(4'b0001, 1'b0, 64'h0101_0101_0101_0101, 40'd0, 24'd0, 14'd0, 8'd0);
    ex1_vld = 1'b1;
    @(posedge clk); #1;
    ex1_src = 64'h2222_2222_2222_2222;
    ex1_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ex1_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %b required 1", ex1_rdy); end
    @(posedge clk); #1;
    ex1_flush = 1'b0; ex1_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_vld) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_kill: %0d outputs seen required 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [55:0] s; logic [7:0] z; int lat; int seen = 0;
    set_in(4'b1000, 1'b0, 64'h0000_0000_00FF_0000, 40'd0, 24'd0, 14'd0, 8'd8);
    run_one(d, s, z, lat);
    set_in(4'b0001, 1'b0, 64'h0303_0303_0303_0303, 40'd0, 24'd0, 14'd0, 8'd0);
    ex1_vld = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    ex1_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0 || out_data !== 64'd0 || out_shamt !== 56'd0 || out_zero !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs: vld=%b data=%h shamt=%h zero=%h required all 0", out_vld, out_data, out_shamt, out_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_vld) seen++;
    end
    checks++;
    if (ex1_rdy !== 1'b1 || seen !== 0) begin
      errors++; $display("FAIL midreset_after: rdy=%b outputs=%0d required 1/0", ex1_rdy, seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream();
    logic [63:0] qd[$]; logic [55:0] qs[$]; logic [7:0] qz[$];
    logic [63:0] ed, ed2; logic [55:0] es; logic [7:0] ez;
    logic [3:0] sz;
    int budget;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 4))
        0: sz = 4'b0001; 1: sz = 4'b0010; 2: sz = 4'b0100; 3: sz = 4'b1000;
        default: sz = 4'($urandom_range(0, 15));
      endcase
      ed = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 3) == 0) ed[8*b +: 8] = 8'h00;
      set_in(sz, 1'($urandom), ed, {8'($urandom), 32'($urandom)}, 24'($urandom), 14'($urandom), 8'($urandom));
      ex1_vld   = ($urandom_range(0, 9) < 7);
      out_rdy   = ($urandom_range(0, 9) < 7);
      ex1_flush = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: output %h with empty scoreboard", out_data);
        end else begin
          ed2 = qd.pop_front(); es = qs.pop_front(); ez = qz.pop_front();
          if (out_data !== ed2 || out_shamt !== es || out_zero !== ez) begin
            errors++;
            $display("FAIL rand_result: got %h/%h/%h required %h/%h/%h", out_data, out_shamt, out_zero, ed2, es, ez);
          end
        end
      end
      if (ex1_flush) begin
        qd.delete(); qs.delete(); qz.delete();
      end else if (ex1_vld && ex1_rdy) begin
        ref_model(ex1_size, ex1_src, ff1_8_bit, ff1_16_bit, ff1_32_bit, ff1_64_bit, ed2, es, ez);
        qd.push_back(ed2); qs.push_back(es); qz.push_back(ez);
      end
      @(posedge clk); #1;
    end
    ex1_vld = 1'b0; ex1_flush = 1'b0; out_rdy = 1'b1;
    budget = 0;
    while (qd.size() > 0 && budget < 20) begin
      @(negedge clk);
      if (out_vld) begin
        checks++;
        ed2 = qd.pop_front(); es = qs.pop_front(); ez = qz.pop_front();
        if (out_data !== ed2 || out_shamt !== es || out_zero !== ez) begin
          errors++;
          $display("FAIL rand_drain: got %h/%h/%h required %h/%h/%h", out_data, out_shamt, out_zero, ed2, es, ez);
        end
      end
      budget++;
      @(posedge clk); #1;
    end
    checks++;
    if (qd.size() != 0) begin errors++; $display("FAIL rand_timeout: %0d results missing", qd.size()); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_signed();
    test_dword();
    test_word_clamp();
    test_size_decode();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
